// File: rtl/capture_ctrl.sv
// Acquisition controller: paces RAM queue writes, arms the trigger, counts post-trigger samples.
// Latency: all outputs registered; trigger in cycle n -> POST in n+1; final post write in n -> done pulse in n+1.
// Backpressure: none; sampling is free-running at 2^decimator clocks and only run/capture_done gate it.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            capture_done,
    input  logic [3:0]      decimator,
    input  logic [LOG2-1:0] trig_pos,
    input  logic            triggered,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            set_capture_done,
    output logic [LOG2-1:0] ram_addr
);

    localparam int CW = LOG2 + 1;
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, POST, DONE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     dec_cnt, dec_nxt, dec_max;
    logic [CW-1:0]   smpl_cnt, smpl_nxt, post_cnt, post_nxt, thr;
    logic [LOG2-1:0] waddr_nxt, ram_nxt, tp;
    logic            we_nxt, armed_nxt, done_nxt, active, active_nxt;

    assign tp      = (trig_pos > LAST) ? LAST : trig_pos;
    assign thr     = CW'(ENTRIES) - CW'(tp);
    assign dec_max = (16'd1 << decimator) - 16'd1;
    assign active  = (state == SAMPLE) || (state == POST);

    always_comb begin
        state_nxt = state;
        smpl_nxt  = smpl_cnt;
        post_nxt  = post_cnt;
        waddr_nxt = waddr;
        ram_nxt   = ram_addr;
        if (we)
            waddr_nxt = (waddr == LAST) ? '0 : waddr + 1'b1;

        case (state)
            IDLE: begin
                if (run && !capture_done) begin
                    state_nxt = SAMPLE;
                    waddr_nxt = '0;
                    smpl_nxt  = '0;
                    post_nxt  = '0;
                end
            end
            SAMPLE: begin
                if (we && (smpl_cnt < CW'(ENTRIES)))
                    smpl_nxt = smpl_cnt + 1'b1;
                if (!run) begin
                    state_nxt = IDLE;
                end else if (armed && triggered) begin
                    // The sample written in the trigger cycle is the first post-trigger sample
                    post_nxt  = CW'(we);
                    state_nxt = (CW'(we) >= CW'(tp)) ? DONE : POST;
                end
            end
            POST: begin
                post_nxt = post_cnt + CW'(we);
                if (!run)
                    state_nxt = IDLE;
                else if (we && (post_nxt >= CW'(tp)))
                    state_nxt = DONE;
            end
            DONE: begin
                if (!capture_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        active_nxt = (state_nxt == SAMPLE) || (state_nxt == POST);

        // Counter restarts at 0 on SAMPLE entry so the first strobe lands in the first SAMPLE cycle
        dec_nxt = 16'd0;
        if (active && active_nxt)
            dec_nxt = (dec_cnt >= dec_max) ? 16'd0 : dec_cnt + 16'd1;

        we_nxt    = active_nxt && (dec_nxt == 16'd0);
        armed_nxt = active_nxt && (armed || (smpl_nxt >= thr));
        done_nxt  = (state_nxt == DONE) && (state != DONE);
        if (done_nxt)
            ram_nxt = waddr_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            dec_cnt          <= '0;
            smpl_cnt         <= '0;
            post_cnt         <= '0;
            waddr            <= '0;
            ram_addr         <= '0;
            we               <= 1'b0;
            armed            <= 1'b0;
            set_capture_done <= 1'b0;
        end else begin
            state            <= state_nxt;
            dec_cnt          <= dec_nxt;
            smpl_cnt         <= smpl_nxt;
            post_cnt         <= post_nxt;
            waddr            <= waddr_nxt;
            ram_addr         <= ram_nxt;
            we               <= we_nxt;
            armed            <= armed_nxt;
            set_capture_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: each capture's write times, addresses, arming and completion are
// predicted in closed form from the configuration and the chosen trigger cycle.
module tb_capture_ctrl;

    localparam int ENT  = 384;
    localparam int LOG2 = 9;

    logic            clk, rst_n, run, capture_done, triggered;
    logic [3:0]      decimator;
    logic [LOG2-1:0] trig_pos;
    logic            we, armed, set_capture_done;
    logic [LOG2-1:0] waddr, ram_addr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = -1;
    int exp_ram     = 0;

    capture_ctrl #(.ENTRIES(ENT), .LOG2(LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .capture_done(capture_done),
        .decimator(decimator), .trig_pos(trig_pos), .triggered(triggered),
        .we(we), .waddr(waddr), .armed(armed),
        .set_capture_done(set_capture_done), .ram_addr(ram_addr)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One capture. c = 0 is the first SAMPLE cycle. Writes land on every P-th cycle; write
    // number j goes to address (j-1) mod ENT. Arming follows write ENT-tp by one cycle; the
    // capture ends after tp writes counted from the trigger cycle itself.
    task automatic do_capture(input int d, input int tpr, input bit hold, input int dly,
                              input int early, input int abort_at);
        int p, tp, thr, a, c_t, m0, c_d, c_end, n_wr, wb, wexp;
        p   = 1 << d;
        tp  = (tpr > ENT - 1) ? ENT - 1 : tpr;
        thr = ENT - tp;
        a   = (thr - 1) * p + 1;
        c_t = hold ? a : a + dly;
        if (tp == 0) begin
            c_d = c_t + 1;
        end else begin
            m0  = ((c_t + p - 1) / p) * p;
            c_d = m0 + (tp - 1) * p + 1;
        end
        c_end = (abort_at >= 0) ? abort_at + 1 : c_d;
        n_wr  = (c_end - 1) / p + 1;

        decimator    = 4'(d);
        trig_pos     = LOG2'(tpr);
        run          = 1'b1;
        capture_done = 1'b0;
        triggered    = hold;
        for (int c = 0; c <= c_end + 1; c++) begin
            step();
            cyc = c;
            if (!hold)
                triggered = (c == c_t) || (early >= 0 && c == early);
            if (c == abort_at)
                run = 1'b0;
            wb   = (c < c_end) ? c : c_end;
            wexp = (wb == 0) ? 0 : ((wb - 1) / p + 1) % ENT;
            chk("we", 32'(we), 32'(c < c_end && (c % p) == 0));
            chk("waddr", 32'(waddr), wexp);
            chk("armed", 32'(armed), 32'(c >= a && c < c_end));
            chk("set_capture_done", 32'(set_capture_done), 32'(abort_at < 0 && c == c_d));
            if (abort_at < 0 && c == c_d)
                exp_ram = n_wr % ENT;
            chk("ram_addr", 32'(ram_addr), exp_ram);
            if (abort_at < 0 && c == c_d)
                capture_done = 1'b1;
        end
        triggered = 1'b0;

        // capture_done held with run high must not start a new capture
        run          = 1'b1;
        capture_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_we", 32'(we), 0);
            chk("hold_waddr", 32'(waddr), n_wr % ENT);
            chk("hold_done", 32'(set_capture_done), 0);
        end
        run          = 1'b0;
        capture_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("idle_we", 32'(we), 0);
            chk("idle_ram_addr", 32'(ram_addr), exp_ram);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        capture_done = 1'b0;
        triggered    = 1'b0;
        decimator    = 4'd0;
        trig_pos     = '0;
        #3;
        chk("rst_we", 32'(we), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_done", 32'(set_capture_done), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        #9 rst_n = 1'b1;
        step();
        chk("idle_we0", 32'(we), 0);

        do_capture(0, 4, 1'b1, 0, -1, -1);    // held trigger: 384 writes, ram_addr 0
        do_capture(0, 4, 1'b0, 100, -1, -1);  // late trigger: 484 writes, ram_addr 100
        do_capture(2, 20, 1'b0, 7, 30, -1);   // decimated, early ignored trigger
        do_capture(1, 0, 1'b0, 5, -1, -1);    // trig_pos 0
        do_capture(0, 1, 1'b1, 0, -1, -1);    // single post sample
        do_capture(0, 4, 1'b1, 0, -1, 382);   // abort during POST
        do_capture(0, 4, 1'b1, 0, -1, -1);    // restart after abort
        do_capture(0, 500, 1'b0, 3, -1, -1);  // clamped trig_pos
        for (int r = 0; r < 4; r++)
            do_capture(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), -1, -1);

        // asynchronous reset in the middle of a capture
        decimator    = 4'd0;
        trig_pos     = LOG2'(383);
        triggered    = 1'b0;
        run          = 1'b1;
        capture_done = 1'b0;
        repeat (20) step();
        cyc = 1000;
        chk("pre_rst_armed", 32'(armed), 1);
        chk("pre_rst_we", 32'(we), 1);
        #2 rst_n = 1'b0;
        #1;
        exp_ram = 0;
        chk("arst_we", 32'(we), 0);
        chk("arst_waddr", 32'(waddr), 0);
        chk("arst_armed", 32'(armed), 0);
        chk("arst_done", 32'(set_capture_done), 0);
        chk("arst_ram_addr", 32'(ram_addr), 0);
        run = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_we", 32'(we), 0);
        chk("post_rst_done", 32'(set_capture_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
